float_to_int: RTL

Multi-cycle IEEE-754 single-precision to 32-bit integer converter (RISC-V FCVT.W.S / FCVT.WU.S) in the FPU, the reverse-direction partner of the integer-to-float stage.
- Consumes a float operand from the FPU operand mux and produces an integer result plus exception flags for integer writeback and fcsr.
- Uses one shift per cycle and separate round and pack steps, so it closes timing alongside the other sequential FPU units.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fp_round_decide.sv | 38 +++
 rtl/float_to_int.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared FPU definitions: rounding-mode and sequencer state encodings, fcsr
// flag bit positions and the integer saturation constants used by the
// float<->int conversion stages.
// -----------------------------------------------------------------------------
package fpu_pkg;

  // RISC-V rm field encodings; 5-7 are treated as RNE by consumers.
  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_SHIFT,
    S_ROUND,
    S_PACK,
    S_DONE
  } state_e;

  // Bit positions inside the 2-bit {NV, NX} flag vector.
  localparam int FLAG_NV = 1;
  localparam int FLAG_NX = 0;

  localparam int EXP_BIAS = 127;

  localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/fp_round_decide.sv
// -----------------------------------------------------------------------------
// fp_round_decide
// Combinational rounding decision shared by the FPU rounding stages.
//   rm      : rounding mode (RNE/RTZ/RDN/RUP/RMM, 5-7 behave as RNE)
//   sign    : sign of the value being rounded
//   lsb     : least significant kept bit of the magnitude
//   g       : guard bit (first discarded bit)
//   st      : sticky, OR of all bits below the guard
//   inc     : add one ulp to the truncated magnitude
//   inexact : any discarded bit was set
// -----------------------------------------------------------------------------
module fp_round_decide
  import fpu_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       st,
  output logic       inc,
  output logic       inexact
);

  // NOTE: every output of a combinational block gets a value before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    inexact = g | st;
    inc     = g & (st | lsb);  // RNE, also used for the reserved encodings
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | st);
      RM_RUP:  inc = ~sign & (g | st);
      RM_RMM:  inc = g;
      default: ;
    endcase
  end

endmodule

// File: rtl/float_to_int.sv
// -----------------------------------------------------------------------------
// float_to_int
// Multi-cycle IEEE-754 single to 32-bit integer converter (FCVT.W.S and
// FCVT.WU.S). The mantissa is aligned one bit position per cycle, then
// rounded, then clamped into the integer range.
//   clk, rst      : clock, asynchronous active-low reset
//   input_a       : float operand, captured with rm and is_unsigned
//   in_valid      : operand valid; accepted when in_ready (IDLE only)
//   output_z      : integer result
//   output_flags  : {NV, NX}
//   output_z_stb  : result valid, held with data until out_ready
// -----------------------------------------------------------------------------
module float_to_int
  import fpu_pkg::*;
#(
  parameter int SHIFT_CAP = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [2:0]  rm,
  input  logic        is_unsigned,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] output_z,
  output logic [1:0]  output_flags,
  output logic        output_z_stb,
  input  logic        out_ready
);

  // Magnitude just above every clamp threshold: Inf, NaN and e>=32 load it so
  // the normal clamp produces their saturated result and NV.
  localparam logic [32:0] SAT_MAG = 33'h1_0000_0000;

  state_e      state, state_next;

  logic [31:0] a_q;
  logic [2:0]  rm_q;
  logic        uns_q;
  logic        s_q;
  logic        left_q;
  logic [7:0]  cnt_q;
  logic [55:0] acc_q;     // 32 integer bits . 24 fraction bits
  logic        sticky_q;  // bits shifted out below the fraction field
  logic [32:0] mag_q;
  logic        nx_q;

  // ---------------------------------------------------------------- unpack
  logic [7:0]        exp_f;
  logic [22:0]       frac_f;
  logic              hidden;
  logic signed [9:0] e;
  logic [7:0]        e_abs;
  logic [7:0]        unpack_cnt;
  logic              is_zero, is_nan, early_pack;

  always_comb begin
    exp_f  = a_q[30:23];
    frac_f = a_q[22:0];
    hidden = (exp_f != 8'd0);
    // Denormals use the minimum normal exponent with a zero hidden bit.
    e      = hidden ? $signed({2'b00, exp_f}) - $signed(10'(EXP_BIAS))
                    : $signed(10'(1 - EXP_BIAS));
    e_abs  = e[9] ? 8'(-e) : 8'(e);
    is_zero    = !hidden && (frac_f == 23'd0);
    is_nan     = (exp_f == 8'hFF) && (frac_f != 23'd0);
    early_pack = is_zero || (exp_f == 8'hFF) || (!e[9] && e >= 10'sd32);
    // Past SHIFT_CAP right shifts every mantissa bit already sits in sticky.
    if (e[9] && e_abs > 8'(SHIFT_CAP)) unpack_cnt = 8'(SHIFT_CAP);
    else                               unpack_cnt = e_abs;
  end

  // ----------------------------------------------------------------- round
  logic st_round, inc, inexact;

  assign st_round = (|acc_q[22:0]) | sticky_q;

  fp_round_decide u_round_decide (
    .rm      (rm_q),
    .sign    (s_q),
    .lsb     (acc_q[24]),
    .g       (acc_q[23]),
    .st      (st_round),
    .inc     (inc),
    .inexact (inexact)
  );

  // ------------------------------------------------------------------ pack
  logic [31:0] pack_z;
  logic        pack_nv;
  logic [1:0]  pack_flags;

  always_comb begin
    pack_z  = mag_q[31:0];
    pack_nv = 1'b0;
    if (!uns_q) begin
      if (!s_q && mag_q > {1'b0, INT_MAX}) begin
        pack_z  = INT_MAX;
        pack_nv = 1'b1;
      end else if (s_q && mag_q > {1'b0, INT_MIN}) begin
        pack_z  = INT_MIN;
        pack_nv = 1'b1;
      end else if (s_q) begin
        pack_z  = 32'd0 - mag_q[31:0];
      end
    end else begin
      if (s_q) begin
        // Negative values that round to zero are legal (0, inexact only).
        pack_z  = 32'd0;
        pack_nv = (mag_q != 33'd0);
      end else if (mag_q > {1'b0, UINT_MAX}) begin
        pack_z  = UINT_MAX;
        pack_nv = 1'b1;
      end
    end
    pack_flags          = 2'b00;
    pack_flags[FLAG_NV] = pack_nv;
    pack_flags[FLAG_NX] = nx_q & ~pack_nv;
  end

  // ------------------------------------------------------------------- FSM
  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (in_valid) state_next = S_UNPACK;
      S_UNPACK: begin
        if (early_pack)              state_next = S_PACK;
        else if (unpack_cnt != 8'd0) state_next = S_SHIFT;
        else                         state_next = S_ROUND;
      end
      S_SHIFT:  if (cnt_q == 8'd1) state_next = S_ROUND;
      S_ROUND:  state_next = S_PACK;
      S_PACK:   state_next = S_DONE;
      S_DONE:   if (out_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- datapath
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q          <= '0;
      rm_q         <= '0;
      uns_q        <= 1'b0;
      s_q          <= 1'b0;
      left_q       <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      mag_q        <= '0;
      nx_q         <= 1'b0;
      output_z     <= '0;
      output_flags <= '0;
      output_z_stb <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= input_a;
            rm_q  <= rm;
            uns_q <= is_unsigned;
          end
        end
        S_UNPACK: begin
          // NaN converts like +Inf whatever its sign bit.
          s_q      <= a_q[31] & ~is_nan;
          left_q   <= !e[9];
          cnt_q    <= unpack_cnt;
          acc_q    <= {31'b0, hidden, frac_f, 1'b0};
          sticky_q <= 1'b0;
          mag_q    <= is_zero ? 33'd0 : SAT_MAG;
          nx_q     <= 1'b0;
        end
        S_SHIFT: begin
          if (left_q) begin
            acc_q <= acc_q << 1;
          end else begin
            acc_q    <= acc_q >> 1;
            sticky_q <= sticky_q | acc_q[0];
          end
          cnt_q <= cnt_q - 8'd1;
        end
        S_ROUND: begin
          mag_q <= {1'b0, acc_q[55:24]} + 33'(inc);
          nx_q  <= inexact;
        end
        S_PACK: begin
          output_z     <= pack_z;
          output_flags <= pack_flags;
          output_z_stb <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) output_z_stb <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
